// File: rtl/conv_window_5x5.sv
// 5x5 sliding-window assembler: shifts five row-aligned taps per accepted pixel
// and presents each fully-populated window with its output coordinates.
module conv_window_5x5 #(
  parameter int IMG_WIDTH  = 32,
  parameter int IMG_HEIGHT = 32,
  parameter int K          = 5,
  parameter int DW         = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid_in,
  output logic                in_ready,
  input  logic [DW-1:0]       tap0,
  input  logic [DW-1:0]       tap1,
  input  logic [DW-1:0]       tap2,
  input  logic [DW-1:0]       tap3,
  input  logic [DW-1:0]       tap4,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [K*K*DW-1:0]   win_data,
  output logic [4:0]          win_col,
  output logic [4:0]          win_row,
  output logic                win_last
);

  localparam logic [4:0] X_LAST = 5'(IMG_WIDTH - 1);
  localparam logic [4:0] Y_LAST = 5'(IMG_HEIGHT - 1);
  localparam logic [4:0] EDGE   = 5'(K - 1);

  // Handshake: a window is transferred when win_valid && win_ready at a rising
  // edge; taps are consumed when valid_in && in_ready, and in_ready only drops
  // while an un-taken window is being held.
  logic [4:0]    x_cnt;
  logic [4:0]    y_cnt;
  logic [DW-1:0] win   [K][K];
  logic [DW-1:0] taps  [K];
  logic          accept;
  logic          x_end;
  logic          y_end;
  logic          full_win;

  assign in_ready = !win_valid || win_ready;
  assign accept   = valid_in && in_ready;
  assign x_end    = (x_cnt == X_LAST);
  assign y_end    = (y_cnt == Y_LAST);
  assign full_win = (x_cnt >= EDGE) && (y_cnt >= EDGE);

  // Row 0 of the window is the oldest line, so it takes the deepest tap.
  assign taps[0] = tap4;
  assign taps[1] = tap3;
  assign taps[2] = tap2;
  assign taps[3] = tap1;
  assign taps[4] = tap0;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (accept) begin
      if (x_end) begin
        x_cnt <= '0;
        y_cnt <= y_end ? 5'd0 : y_cnt + 5'd1;
      end else begin
        x_cnt <= x_cnt + 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win[r][c] <= win[r][c+1];
        end
        win[r][K-1] <= taps[r];
      end
    end
  end

  always_comb begin
    win_data = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        win_data[(r*K+c)*DW +: DW] = win[r][c];
      end
    end
  end

  // Coordinates are taken from the pre-increment counters, i.e. the pixel just
  // accepted is the bottom-right corner of the new window.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_col   <= '0;
      win_row   <= '0;
      win_last  <= 1'b0;
    end else if (accept) begin
      win_valid <= full_win;
      if (full_win) begin
        win_col  <= x_cnt - EDGE;
        win_row  <= y_cnt - EDGE;
        win_last <= x_end && y_end;
      end
    end else if (win_ready) begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_5x5.sv
// Directed bench for conv_window_5x5: ramp frames, back-to-back wrap, bubbles,
// output stall and mid-frame reset, checked against a pixel-function model.
module tb_conv_window_5x5;

  localparam int DW = 8;
  localparam int K  = 5;
  localparam int WD = K*K*DW;
  localparam int EW = WD + 11;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_in;
  logic          in_ready;
  logic [DW-1:0] tap0, tap1, tap2, tap3, tap4;
  logic          win_valid;
  logic          win_ready;
  logic [WD-1:0] win_data;
  logic [4:0]    win_col;
  logic [4:0]    win_row;
  logic          win_last;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] held;
  logic          prev_hold = 1'b0;
  logic          prev_drop = 1'b0;
  int            errors = 0;
  int            checks = 0;
  int            win_cnt = 0;
  int            cycles = 0;

  always #5 clk = ~clk;

  conv_window_5x5 dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
    .tap0(tap0), .tap1(tap1), .tap2(tap2), .tap3(tap3), .tap4(tap4),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_col(win_col), .win_row(win_row), .win_last(win_last)
  );

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int x, input int y);
    return DW'((y*32 + x) & 255);
  endfunction

  function automatic logic [WD-1:0] model_win(input int col, input int row);
    logic [WD-1:0] d;
    d = '0;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K; c++) begin
        d[(r*K+c)*DW +: DW] = pix(col + c, row + r);
      end
    end
    return d;
  endfunction

  task automatic set_taps(input int x, input int y);
    tap0 = pix(x, y);
    tap1 = (y >= 1) ? pix(x, y-1) : '0;
    tap2 = (y >= 2) ? pix(x, y-2) : '0;
    tap3 = (y >= 3) ? pix(x, y-3) : '0;
    tap4 = (y >= 4) ? pix(x, y-4) : '0;
  endtask

  // One clock: observe outputs at the falling edge, then return at posedge+1.
  task automatic step(output bit acc, input int x, input int y);
    logic [EW-1:0] e;
    @(negedge clk);
    cycles++;
    if (cycles > 40000) begin
      errors++;
      $display("FAIL timeout: cycles %0d exceed budget 40000", cycles);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1);
    end
    check("in_ready", in_ready, !win_valid || win_ready);
    if (prev_hold) check("hold", {win_last, win_row, win_col, win_data}, held);
    if (prev_drop) check("drop", win_valid, 1'b0);
    if (win_valid && win_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_win", win_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check("window", {win_last, win_row, win_col, win_data}, e);
        win_cnt++;
        if (e[209:200] == 10'd0) begin
          check("first_00", win_data[7:0], 8'h00);
          check("first_44", win_data[199:192], 8'h84);
        end
      end
    end
    acc       = valid_in && in_ready && !rst;
    prev_hold = win_valid && !win_ready && !rst;
    prev_drop = !acc && win_ready && !rst;
    held      = {win_last, win_row, win_col, win_data};
    if (acc && x >= 4 && y >= 4)
      exp_q.push_back({(x == 31 && y == 31), 5'(y-4), 5'(x-4), model_win(x-4, y-4)});
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pixel(input int x, input int y, input int duty);
    bit acc;
    acc = 1'b0;
    while (!acc) begin
      valid_in = ($urandom_range(99) < duty);
      if (valid_in) set_taps(x, y);
      else set_taps($urandom_range(31), $urandom_range(31));
      step(acc, x, y);
    end
  endtask

  // Window (5,7) is held for three cycles while pixel (10,11) is offered.
  task automatic stall();
    bit acc;
    win_ready = 1'b0;
    valid_in  = 1'b1;
    set_taps(10, 11);
    check("stall_pos", {win_valid, win_row, win_col}, {1'b1, 5'd7, 5'd5});
    repeat (3) begin
      step(acc, 10, 11);
      check("stall_accept", acc, 1'b0);
    end
    win_ready = 1'b1;
  endtask

  task automatic send_frame(input int duty, input bit stall_on, input bit cut);
    for (int y = 0; y < 32; y++) begin
      for (int x = 0; x < 32; x++) begin
        drive_pixel(x, y, duty);
        if (stall_on && x == 9 && y == 11) stall();
        if (cut && x == 10 && y == 12) return;
      end
    end
  endtask

  task automatic drain(input int exp_cnt, input string tag);
    bit acc;
    valid_in  = 1'b0;
    win_ready = 1'b1;
    repeat (2) step(acc, 0, 0);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_count"}, win_cnt, exp_cnt);
  endtask

  task automatic check_cleared(input string tag);
    win_ready = 1'b0;
    #1;
    check({tag, "_valid"}, win_valid, 1'b0);
    check({tag, "_data"}, win_data, '0);
    check({tag, "_coord"}, {win_last, win_row, win_col}, 11'd0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    win_ready = 1'b1;
  endtask

  initial begin
    bit acc;
    rst = 1'b1;
    valid_in = 1'b0;
    win_ready = 1'b1;
    set_taps(0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_cleared("reset");

    // Two back-to-back continuous frames.
    win_cnt = 0;
    send_frame(100, 1'b0, 1'b0);
    send_frame(100, 1'b0, 1'b0);
    drain(1568, "two_frames");

    // Input bubbles plus an output stall on window (5,7).
    win_cnt = 0;
    send_frame(50, 1'b1, 1'b0);
    drain(784, "bubbles");

    // Reset while window (6,8) is pending; 230 windows precede it.
    win_cnt = 0;
    send_frame(100, 1'b0, 1'b1);
    check("pre_rst_valid", win_valid, 1'b1);
    check("pre_rst_count", win_cnt, 230);
    win_ready = 1'b0;
    valid_in  = 1'b0;
    rst       = 1'b1;
    step(acc, 0, 0);
    rst = 1'b0;
    check("pending_q", exp_q.size(), 1);
    void'(exp_q.pop_back());
    prev_hold = 1'b0;
    prev_drop = 1'b0;
    check_cleared("mid_reset");
    win_cnt = 0;
    send_frame(100, 1'b0, 1'b0);
    drain(784, "restart");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
